imm_ext_unit: RTL and testbench

Parametrised, registered immediate-generation stage for the multicycle MIPS datapath. It replaces the fixed 16→32 combinational sign extender with a width-generic extender supporting zero, sign, upper-immediate and branch-offset modes, and places a ready/valid two-entry skid buffer between the instruction-register decode and the ALU operand mux. Operand generation is decoupled from stalls, and every result carries a one-cycle latency.

---
 rtl/imm_ext_pkg.sv | 21 ++
 rtl/imm_ext_if.sv | 27 ++
 rtl/imm_ext_core.sv | 50 +++++
 rtl/imm_ext_unit.sv | 103 ++++++++++
 tb/tb_imm_ext_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared types and width defaults for the immediate-extension stage.
package imm_ext_pkg;

    localparam int unsigned IMM_IN_W_DEF  = 16;
    localparam int unsigned IMM_OUT_W_DEF = 32;

    typedef enum logic [1:0] {
        IMM_ZERO   = 2'd0,
        IMM_SIGN   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

    // Occupancy of the main/skid register pair.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/imm_ext_if.sv
// imm_ext_if: ready/valid bus between IR decode, the extension stage and the ALU operand mux.
// slave  = view of the extension unit, master = view of the surrounding datapath.
interface imm_ext_if
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W_DEF,
    parameter int unsigned OUT_W = IMM_OUT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    imm_mode_e        in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic             out_neg;

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_imm, out_neg
    );

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_imm, out_neg
    );
endinterface

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational width-generic immediate extender.
// Macro IMM_EXT_BRANCH_EN: when defined, mode 3 sign-extends and shifts left by
// BR_SHIFT; when undefined, mode 3 behaves as SIGN and no shifter is built.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W     = IMM_IN_W_DEF,
    parameter int unsigned OUT_W    = IMM_OUT_W_DEF,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  i_imm,
    input  imm_mode_e        i_mode,
    output logic [OUT_W-1:0] o_ext
);

    if ((IN_W < 2) || (IN_W >= OUT_W) || (BR_SHIFT >= OUT_W - IN_W)) begin : g_param_check
        $error("imm_ext_core: invalid IN_W/OUT_W/BR_SHIFT combination");
    end

    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_upper;

    assign w_zero  = {{(OUT_W-IN_W){1'b0}}, i_imm};
    assign w_sign  = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
    assign w_upper = {i_imm, {(OUT_W-IN_W){1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
    logic [OUT_W-1:0] w_branch;
    // Bits shifted past the MSB fall off; low BR_SHIFT bits fill with zero.
    assign w_branch = w_sign << BR_SHIFT;
`endif

    // Select the extension form for the requested mode.
    always_comb begin
        o_ext = w_zero;
        case (i_mode)
            IMM_ZERO:   o_ext = w_zero;
            IMM_SIGN:   o_ext = w_sign;
            IMM_UPPER:  o_ext = w_upper;
`ifdef IMM_EXT_BRANCH_EN
            IMM_BRANCH: o_ext = w_branch;
`else
            IMM_BRANCH: o_ext = w_sign;
`endif
            default:    o_ext = w_zero;
        endcase
    end

endmodule

// File: rtl/imm_ext_unit.sv
// imm_ext_unit: registered immediate-generation stage with a two-entry skid buffer.
// Macro IMM_EXT_BRANCH_EN (passed through to imm_ext_core) enables BRANCH mode.
// Results are computed once on acceptance and stored; out_* come straight from
// registers and in_ready is registered from the next occupancy state.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W     = IMM_IN_W_DEF,
    parameter int unsigned OUT_W    = IMM_OUT_W_DEF,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    imm_ext_if.slave   bus
);

    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_main;
    logic [OUT_W-1:0] r_skid;
    logic [OUT_W-1:0] w_main_nxt;
    logic [OUT_W-1:0] w_skid_nxt;
    occ_state_e       r_state;
    occ_state_e       w_state_nxt;
    logic             r_in_ready;
    logic             w_acc;
    logic             w_drn;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .i_imm  (bus.in_imm),
        .i_mode (bus.in_mode),
        .o_ext  (w_ext)
    );

    // Handshake qualifiers; both are based on registered readiness/occupancy only.
    always_comb begin
        w_acc = bus.in_valid && r_in_ready;
        w_drn = (r_state != OCC_EMPTY) && bus.out_ready;
    end

    // Next occupancy and register contents; flush overrides any accept or drain.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = OCC_ONE;
                        w_main_nxt  = w_ext;
                    end
                end
                OCC_ONE: begin
                    if (w_acc && w_drn) begin
                        w_main_nxt = w_ext;
                    end else if (w_acc) begin
                        w_state_nxt = OCC_FULL;
                        w_skid_nxt  = w_ext;
                    end else if (w_drn) begin
                        w_state_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_drn) begin
                        w_state_nxt = OCC_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = OCC_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers; in_ready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= OCC_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != OCC_FULL);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != OCC_EMPTY);
    assign bus.out_imm   = r_main;
    assign bus.out_neg   = r_main[OUT_W-1];

endmodule

// File: tb/tb_imm_ext_unit.sv
// tb_imm_ext_unit: self-checking bench for imm_ext_unit (default and 8->16 instances).
module tb_imm_ext_unit;
    import imm_ext_pkg::*;

`ifdef IMM_EXT_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic s_flush;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    imm_ext_if #(.IN_W(16), .OUT_W(32)) bus ();
    imm_ext_if #(.IN_W(8),  .OUT_W(16)) sbus ();

    imm_ext_unit #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    imm_ext_unit #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (s_flush),
        .bus   (sbus.slave)
    );

    // Arithmetic reference: extension expressed as modular integer arithmetic.
    function automatic longint unsigned ref_ext(input longint unsigned imm, input int mode,
                                                input int iw, input int ow, input int sh);
        longint unsigned modv = 64'd1 << ow;
        longint unsigned s;
        s = (imm >= (64'd1 << (iw - 1))) ? imm + modv - (64'd1 << iw) : imm;
        case (mode)
            0:       return imm;
            1:       return s;
            2:       return (imm * (64'd1 << (ow - iw))) % modv;
            default: return BR_EN ? (s * (64'd1 << sh)) % modv : s;
        endcase
    endfunction

    // One cycle on the default instance: drive at negedge, check, update the queue model.
    task automatic cycle(input bit v, input logic [15:0] imm, input int mode,
                         input bit ordy, input bit fl);
        bit acc;
        bit drn;
        bus.in_valid  = v;
        bus.in_imm    = imm;
        bus.in_mode   = imm_mode_e'(2'(mode));
        bus.out_ready = ordy;
        flush         = fl;
        n_checks++;
        if (bus.out_valid !== (q.size() != 0))
            $display("FAIL out_valid: got %b want %b", bus.out_valid, q.size() != 0);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== (q.size() < 2))
            $display("FAIL in_ready: got %b want %b", bus.in_ready, q.size() < 2);
        else n_pass++;
        if (q.size() != 0) begin
            n_checks++;
            if (bus.out_imm !== q[0])
                $display("FAIL out_imm: got %h want %h", bus.out_imm, q[0]);
            else n_pass++;
            n_checks++;
            if (bus.out_neg !== q[0][31])
                $display("FAIL out_neg: got %b want %b", bus.out_neg, q[0][31]);
            else n_pass++;
        end
        acc = v && (q.size() < 2);
        drn = (q.size() != 0) && ordy;
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(32'(ref_ext(64'(imm), mode, 16, 32, 2)));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_imm !== 32'h0 || bus.out_neg !== 1'b0)
            $display("FAIL reset_data: got %h neg=%b want 0 neg=0", bus.out_imm, bus.out_neg);
        else n_pass++;
    endtask

    task automatic test_modes();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h00008001;
        exp_tab[1] = 32'hFFFF8001;
        exp_tab[2] = 32'h80010000;
        exp_tab[3] = BR_EN ? 32'hFFFE0004 : 32'hFFFF8001;
        for (int m = 0; m < 4; m++) begin
            cycle(1'b1, 16'h8001, m, 1'b1, 1'b0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_imm !== exp_tab[m])
                $display("FAIL mode%0d: got v=%b %h want v=1 %h", m, bus.out_valid, bus.out_imm, exp_tab[m]);
            else n_pass++;
            n_checks++;
            if (bus.out_neg !== exp_tab[m][31])
                $display("FAIL mode%0d_neg: got %b want %b", m, bus.out_neg, exp_tab[m][31]);
            else n_pass++;
        end
        cycle(1'b0, 16'h0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 16'h0001, 1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0002, 1, 1'b0, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b0)
            $display("FAIL bp_full_ready: got %b want 0", bus.in_ready);
        else n_pass++;
        cycle(1'b1, 16'h0003, 1, 1'b0, 1'b0);
        n_checks++;
        if (bus.out_imm !== 32'h1)
            $display("FAIL bp_hold: got %h want 00000001", bus.out_imm);
        else n_pass++;
        cycle(1'b1, 16'h0003, 1, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_imm !== 32'h2)
            $display("FAIL bp_second: got %h want 00000002", bus.out_imm);
        else n_pass++;
        cycle(1'b1, 16'h0003, 1, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_imm !== 32'h3)
            $display("FAIL bp_third: got %h want 00000003", bus.out_imm);
        else n_pass++;
        cycle(1'b0, 16'h0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        cycle(1'b1, 16'h0010, 1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0011, 1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0055, 1, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_state: got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        repeat (3) cycle(1'b0, 16'h0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 16'h1234, 1, 1'b0, 1'b0);
        cycle(1'b1, 16'h8765, 1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_imm !== 32'h0)
            $display("FAIL reset_mid: got v=%b r=%b %h want v=0 r=1 00000000",
                     bus.out_valid, bus.in_ready, bus.out_imm);
        else n_pass++;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 16'h0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), int'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (3) cycle(1'b0, 16'h0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_small_width();
        logic [15:0] exp_tab [4];
        exp_tab[0] = 16'h00C0;
        exp_tab[1] = 16'hFFC0;
        exp_tab[2] = 16'hC000;
        exp_tab[3] = BR_EN ? 16'hFF80 : 16'hFFC0;
        sbus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            sbus.in_valid = 1'b1;
            sbus.in_imm   = 8'hC0;
            sbus.in_mode  = imm_mode_e'(2'(m));
            @(negedge clk);
            sbus.in_valid = 1'b0;
            n_checks++;
            if (sbus.out_valid !== 1'b1 || sbus.out_imm !== exp_tab[m])
                $display("FAIL small_mode%0d: got v=%b %h want v=1 %h", m, sbus.out_valid, sbus.out_imm, exp_tab[m]);
            else n_pass++;
            n_checks++;
            if (sbus.out_imm !== 16'(ref_ext(64'hC0, m, 8, 16, 1)))
                $display("FAIL small_model%0d: got %h want %h", m, sbus.out_imm, 16'(ref_ext(64'hC0, m, 8, 16, 1)));
            else n_pass++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        s_flush        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_imm     = '0;
        bus.in_mode    = IMM_ZERO;
        bus.out_ready  = 1'b0;
        sbus.in_valid  = 1'b0;
        sbus.in_imm    = '0;
        sbus.in_mode   = IMM_ZERO;
        sbus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_modes();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        test_small_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
